// File: rtl/control_pkg.sv
// Shared types, opcode encodings and decode helpers for the instruction control sequencer.
package control_pkg;

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_FETCH_WAIT, S_INC_PC, S_DECODE, S_RD_X, S_RD_Y,
      S_ALU, S_WB, S_MEM_REQ, S_MEM_WAIT, S_MEM_WB, S_JUMP, S_TRAP
   } state_t;

   typedef struct packed {
      logic pc_reset;
      logic ir_load;
      logic pc_inc;
      logic rx_rd;
      logic ry_rd;
      logic imm_sel;
      logic alu_en;
      logic flag_wr;
      logic rx_wr_alu;
      logic rx_wr_mem;
      logic mem_addr_ld;
      logic pc_load;
      logic link_wr;
   } ctrl_t;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_CMP  = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_MVHI = 4'b0110;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_JZ   = 4'b1001;
   localparam logic [3:0] OP_JN   = 4'b1010;
   localparam logic [3:0] OP_CALL = 4'b1100;

   // Latency counter width: holds MEM_LAT-1 for MEM_LAT up to 7.
   localparam int LAT_W = 3;

   function automatic logic is_legal(input logic imm, input logic [3:0] op);
      case (op)
         OP_MV, OP_ADD, OP_SUB, OP_CMP,
         OP_J, OP_JZ, OP_JN, OP_CALL: return 1'b1;
         OP_LD, OP_ST:                return !imm;
         OP_MVHI:                     return imm;
         default:                     return 1'b0;
      endcase
   endfunction

   function automatic logic is_jump(input logic [3:0] op);
      return op inside {OP_J, OP_JZ, OP_JN, OP_CALL};
   endfunction

   function automatic logic is_mem(input logic [3:0] op);
      return op inside {OP_LD, OP_ST};
   endfunction

endpackage

// File: rtl/latency_counter.sv
// Memory read latency down-counter shared by instruction fetch and data load waits.
module latency_counter
   import control_pkg::*;
#(
   parameter int W = LAT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer: fetch, decode, register/ALU/memory/jump phases, trap.
module control_sequencer
   import control_pkg::*;
#(
   parameter int OPC_W   = 5,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [OPC_W-1:0] i_opcode,
   input  logic             i_n,
   input  logic             i_z,
   input  logic             i_mem_waitrequest,
   input  logic             i_stall,
   output logic             o_mem_rd,
   output logic             o_mem_wr,
   output ctrl_t            o_ctrl,
   output state_t           o_state,
   output logic             o_trap,
   output logic [CNT_W-1:0] o_retired
);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_t     state, state_nx;
   logic       imm;
   logic [3:0] op;
   logic       lat_load, lat_done;
   logic       retire;

   assign imm = i_opcode[OPC_W-1];
   assign op  = i_opcode[3:0];

   latency_counter #(.W(LAT_W)) u_lat (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (lat_load),
      .load_val (LAT_LOAD),
      .done     (lat_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_RESET;
      else          state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx = state;
      o_ctrl   = '0;
      o_mem_rd = 1'b0;
      o_mem_wr = 1'b0;
      lat_load = 1'b0;
      case (state)
         S_RESET: begin
            o_ctrl.pc_reset = 1'b1;
            state_nx        = S_FETCH;
         end
         S_FETCH: begin
            if (!i_stall) begin
               o_mem_rd = 1'b1;
               if (!i_mem_waitrequest) begin
                  lat_load = 1'b1;
                  state_nx = S_FETCH_WAIT;
               end
            end
         end
         S_FETCH_WAIT: begin
            if (lat_done) begin
               o_ctrl.ir_load = 1'b1;
               state_nx       = S_INC_PC;
            end
         end
         S_INC_PC: begin
            o_ctrl.pc_inc = 1'b1;
            state_nx      = S_DECODE;
         end
         S_DECODE: begin
            if (!is_legal(imm, op)) state_nx = S_TRAP;
            else if (is_jump(op))   state_nx = S_JUMP;
            else                    state_nx = S_RD_X;
         end
         S_RD_X: begin
            o_ctrl.rx_rd = 1'b1;
            state_nx     = imm ? S_ALU : S_RD_Y;
         end
         S_RD_Y: begin
            o_ctrl.ry_rd = 1'b1;
            if (is_mem(op)) begin
               o_ctrl.mem_addr_ld = 1'b1;
               state_nx           = S_MEM_REQ;
            end else begin
               state_nx = S_ALU;
            end
         end
         S_ALU: begin
            o_ctrl.alu_en  = 1'b1;
            o_ctrl.imm_sel = imm;
            o_ctrl.flag_wr = op inside {OP_ADD, OP_SUB, OP_CMP};
            state_nx       = (op == OP_CMP) ? S_FETCH : S_WB;
         end
         S_WB: begin
            o_ctrl.rx_wr_alu = 1'b1;
            state_nx         = S_FETCH;
         end
         S_MEM_REQ: begin
            o_mem_rd = (op == OP_LD);
            o_mem_wr = (op == OP_ST);
            if (!i_mem_waitrequest) begin
               if (op == OP_LD) begin
                  lat_load = 1'b1;
                  state_nx = S_MEM_WAIT;
               end else begin
                  state_nx = S_FETCH;
               end
            end
         end
         S_MEM_WAIT: begin
            if (lat_done) state_nx = S_MEM_WB;
         end
         S_MEM_WB: begin
            o_ctrl.rx_wr_mem = 1'b1;
            state_nx         = S_FETCH;
         end
         S_JUMP: begin
            o_ctrl.pc_load = (op == OP_J) || (op == OP_CALL) ||
                             ((op == OP_JZ) && i_z) || ((op == OP_JN) && i_n);
            o_ctrl.link_wr = (op == OP_CALL);
            state_nx       = S_FETCH;
         end
         S_TRAP: state_nx = S_TRAP;
         default: state_nx = S_TRAP;
      endcase
   end

   // Every return to FETCH except the one leaving RESET marks a completed instruction.
   assign retire = (state_nx == S_FETCH) && (state != S_FETCH) && (state != S_RESET);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    o_retired <= '0;
      else if (retire) o_retired <= o_retired + 1'b1;
   end

   assign o_state = state;
   assign o_trap  = (state == S_TRAP);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected cycle traces built from the sequencing rules.
module tb_control_sequencer;
   import control_pkg::*;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int CNT_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b0, rst_b = 1'b0;
   logic [4:0] opcode = '0;
   logic       n = 1'b0, z = 1'b0, wreq = 1'b0, stall = 1'b0;

   logic        rd_a, wr_a, trap_a, rd_b, wr_b, trap_b;
   ctrl_t       ctrl_a, ctrl_b;
   state_t      st_a, st_b;
   logic [15:0] ret_a;
   logic [CNT_B-1:0] ret_b;

   control_sequencer #(.OPC_W(5), .MEM_LAT(LAT_A), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset_n(rst_a), .i_opcode(opcode), .i_n(n), .i_z(z),
      .i_mem_waitrequest(wreq), .i_stall(stall), .o_mem_rd(rd_a), .o_mem_wr(wr_a),
      .o_ctrl(ctrl_a), .o_state(st_a), .o_trap(trap_a), .o_retired(ret_a)
   );

   control_sequencer #(.OPC_W(5), .MEM_LAT(LAT_B), .CNT_W(CNT_B)) u_dut_b (
      .clk(clk), .reset_n(rst_b), .i_opcode(opcode), .i_n(n), .i_z(z),
      .i_mem_waitrequest(wreq), .i_stall(stall), .o_mem_rd(rd_b), .o_mem_wr(wr_b),
      .o_ctrl(ctrl_b), .o_state(st_b), .o_trap(trap_b), .o_retired(ret_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      state_t st;
      ctrl_t  c;
      logic   rd, wr, wreq, stall;
   } step_t;

   step_t trace[$];
   int    sel = 0;
   int    retired_model = 0;
   logic  legal_last;

   function automatic logic [31:0] cur_state();
      return (sel == 0) ? 32'(st_a) : 32'(st_b);
   endfunction

   function automatic logic [31:0] cur_out();
      return (sel == 0) ? 32'({ctrl_a, rd_a, wr_a, trap_a}) : 32'({ctrl_b, rd_b, wr_b, trap_b});
   endfunction

   function automatic logic [31:0] cur_ret();
      return (sel == 0) ? 32'(ret_a) : 32'(ret_b);
   endfunction

   function automatic logic [31:0] exp_out(input step_t s);
      return 32'({s.c, s.rd, s.wr, (s.st == S_TRAP)});
   endfunction

   function automatic logic model_legal(input logic [4:0] o);
      logic [3:0] op;
      op = o[3:0];
      if (op == OP_LD || op == OP_ST) return !o[4];
      if (op == OP_MVHI)              return o[4];
      return op inside {OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_J, OP_JZ, OP_JN, OP_CALL};
   endfunction

   function automatic logic [4:0] rand_legal();
      logic [4:0] o;
      do o = 5'($urandom); while (!model_legal(o));
      return o;
   endfunction

   function automatic step_t mk(input state_t st, input ctrl_t c, input logic rd, input logic wr,
                                input logic wq, input logic sl);
      step_t s;
      s.st = st; s.c = c; s.rd = rd; s.wr = wr; s.wreq = wq; s.stall = sl;
      return s;
   endfunction

   // Expands one instruction into the cycle-by-cycle outputs it must produce.
   task automatic build(input logic [4:0] opc, input logic fn, input logic fz, input int ns,
                        input int wf, input int wm, input int lat, input logic hold_stall);
      logic       imm, dc_s;
      logic [3:0] op;
      ctrl_t      c;
      imm = opc[4];
      op  = opc[3:0];
      trace.delete();
      legal_last = model_legal(opc);
      for (int i = 0; i < ns; i++) trace.push_back(mk(S_FETCH, '0, 1'b0, 1'b0, 1'($urandom), 1'b1));
      for (int i = 0; i < wf; i++) trace.push_back(mk(S_FETCH, '0, 1'b1, 1'b0, 1'b1, 1'b0));
      trace.push_back(mk(S_FETCH, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      dc_s = hold_stall ? 1'b1 : 1'($urandom);
      for (int i = 0; i < lat; i++) begin
         c = '0; c.ir_load = (i == lat - 1);
         trace.push_back(mk(S_FETCH_WAIT, c, 1'b0, 1'b0, 1'($urandom), dc_s));
      end
      c = '0; c.pc_inc = 1'b1;
      trace.push_back(mk(S_INC_PC, c, 1'b0, 1'b0, 1'($urandom), dc_s));
      trace.push_back(mk(S_DECODE, '0, 1'b0, 1'b0, 1'($urandom), dc_s));
      if (!legal_last) begin
         for (int i = 0; i < 20; i++) trace.push_back(mk(S_TRAP, '0, 1'b0, 1'b0, 1'($urandom), 1'($urandom)));
         return;
      end
      if (op inside {OP_J, OP_JZ, OP_JN, OP_CALL}) begin
         c = '0;
         c.pc_load = (op == OP_J) || (op == OP_CALL) || (op == OP_JZ && fz) || (op == OP_JN && fn);
         c.link_wr = (op == OP_CALL);
         trace.push_back(mk(S_JUMP, c, 1'b0, 1'b0, 1'($urandom), dc_s));
         return;
      end
      c = '0; c.rx_rd = 1'b1;
      trace.push_back(mk(S_RD_X, c, 1'b0, 1'b0, 1'($urandom), dc_s));
      if (!imm) begin
         c = '0; c.ry_rd = 1'b1; c.mem_addr_ld = (op == OP_LD || op == OP_ST);
         trace.push_back(mk(S_RD_Y, c, 1'b0, 1'b0, 1'($urandom), dc_s));
      end
      if (op == OP_LD || op == OP_ST) begin
         for (int i = 0; i < wm; i++) trace.push_back(mk(S_MEM_REQ, '0, op == OP_LD, op == OP_ST, 1'b1, dc_s));
         trace.push_back(mk(S_MEM_REQ, '0, op == OP_LD, op == OP_ST, 1'b0, dc_s));
         if (op == OP_LD) begin
            for (int i = 0; i < lat; i++) trace.push_back(mk(S_MEM_WAIT, '0, 1'b0, 1'b0, 1'($urandom), dc_s));
            c = '0; c.rx_wr_mem = 1'b1;
            trace.push_back(mk(S_MEM_WB, c, 1'b0, 1'b0, 1'($urandom), dc_s));
         end
         return;
      end
      c = '0; c.alu_en = 1'b1; c.imm_sel = imm; c.flag_wr = op inside {OP_ADD, OP_SUB, OP_CMP};
      trace.push_back(mk(S_ALU, c, 1'b0, 1'b0, 1'($urandom), dc_s));
      if (op != OP_CMP) begin
         c = '0; c.rx_wr_alu = 1'b1;
         trace.push_back(mk(S_WB, c, 1'b0, 1'b0, 1'($urandom), dc_s));
      end
   endtask

   task automatic run_trace(input string tag, input logic [4:0] opc, input logic fn, input logic fz,
                            input int lim);
      for (int i = 0; i < trace.size() && i < lim; i++) begin
         @(negedge clk);
         if (i == 0) begin
            opcode = opc; n = fn; z = fz;
         end
         wreq  = trace[i].wreq;
         stall = trace[i].stall;
         #1;
         if (i == 0)
            check($sformatf("%s_retired", tag), cur_ret(),
                  32'(retired_model % ((sel == 0) ? 65536 : (1 << CNT_B))));
         check($sformatf("%s[%0d]_state", tag, i), cur_state(), 32'(trace[i].st));
         check($sformatf("%s[%0d]_out", tag, i), cur_out(), exp_out(trace[i]));
      end
   endtask

   task automatic exec(input string tag, input logic [4:0] opc, input logic fn, input logic fz,
                       input int ns, input int wf, input int wm, input logic hold_stall);
      build(opc, fn, fz, ns, wf, wm, (sel == 0) ? LAT_A : LAT_B, hold_stall);
      run_trace(tag, opc, fn, fz, 1000);
      if (legal_last) retired_model++;
   endtask

   task automatic exec_rand(input string tag);
      exec(tag, rand_legal(), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
           $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
   endtask

   task automatic do_reset(input int s);
      ctrl_t c;
      c = '0; c.pc_reset = 1'b1;
      sel = s;
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; wreq = 1'b0; stall = 1'b0;
      #1;
      check("rst_state", cur_state(), 32'(S_RESET));
      check("rst_out", cur_out(), 32'({c, 3'b000}));
      check("rst_retired", cur_ret(), 32'd0);
      repeat (2) @(negedge clk);
      if (s == 0) rst_a = 1'b1;
      else        rst_b = 1'b1;
      #1;
      check("rel_state", cur_state(), 32'(S_RESET));
      check("rel_out", cur_out(), 32'({c, 3'b000}));
      retired_model = 0;
   endtask

   initial begin
      ctrl_t c;
      c = '0; c.pc_reset = 1'b1;

      // Default-latency instance.
      do_reset(0);
      exec("add", {1'b0, OP_ADD}, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      exec("jz_z0", {1'b0, OP_JZ}, 1'b0, 1'b0, 0, 1, 0, 1'b0);
      exec("jz_z1", {1'b1, OP_JZ}, 1'b0, 1'b1, 0, 0, 0, 1'b0);
      exec("jn_n1", {1'b0, OP_JN}, 1'b1, 1'b0, 1, 0, 0, 1'b0);
      exec("call", {1'b1, OP_CALL}, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      exec("st", {1'b0, OP_ST}, 1'b0, 1'b0, 0, 0, 2, 1'b0);
      exec("mvhi", {1'b1, OP_MVHI}, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      exec("cmp_stall", {1'b0, OP_CMP}, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      exec("after_stall", {1'b0, OP_SUB}, 1'b0, 1'b0, 4, 1, 0, 1'b0);
      for (int i = 0; i < 40; i++) exec_rand($sformatf("rand_a%0d", i));

      // Asynchronous reset while a load waits in MEM_REQ.
      build({1'b0, OP_LD}, 1'b0, 1'b0, 0, 0, 6, LAT_A, 1'b0);
      run_trace("abort_ld", {1'b0, OP_LD}, 1'b0, 1'b0, 8);
      #2 rst_a = 1'b0;
      #1;
      check("abort_state", cur_state(), 32'(S_RESET));
      check("abort_out", cur_out(), 32'({c, 3'b000}));
      check("abort_retired", cur_ret(), 32'd0);

      do_reset(0);
      exec("illegal_00111", 5'b00111, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      do_reset(0);
      exec("illegal_ld_imm", {1'b1, OP_LD}, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      do_reset(0);

      // Three-cycle latency, four-bit retired counter.
      do_reset(1);
      exec("ld_lat3", {1'b0, OP_LD}, 1'b0, 1'b0, 0, 0, 2, 1'b0);
      for (int i = 1; i < 16; i++) exec_rand($sformatf("rand_b%0d", i));
      @(negedge clk);
      stall = 1'b1;
      #1;
      check("wrap_retired", cur_ret(), 32'd0);
      check("wrap_state", cur_state(), 32'(S_FETCH));
      for (int i = 0; i < 20; i++) exec_rand($sformatf("rand_c%0d", i));
      do_reset(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
